// File: rtl/load_store_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : load_store_sequencer
// Brief    : Turns core load/store requests into in-word data memory accesses.
//            Define MISALIGNED_SPLIT_EN to split misaligned half/word requests
//            into byte beats; otherwise they complete with a fault.
// Revision : 1.0 - initial release
//==============================================================================
module load_store_sequencer #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [2:0]  data_format,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        resp_valid,
    output logic        resp_fault,
    output logic [31:0] load_data,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [2:0]  mem_data_format,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

`ifdef MISALIGNED_SPLIT_EN
    localparam logic c_split_en = 1'b1;
`else
    localparam logic c_split_en = 1'b0;
`endif

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam int                 c_cnt_w    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(READ_LATENCY - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic               r_is_store;
    logic               r_split;
    logic               r_fault;
    logic [31:0]        r_addr;
    logic [2:0]         r_fmt;
    logic [31:0]        r_wdata;
    logic [1:0]         r_idx;
    logic [1:0]         r_last_idx;
    logic [31:0]        r_acc;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic [31:0]        r_hold_addr;
    logic [2:0]         r_hold_fmt;
    logic [31:0]        r_hold_wdata;

    logic               w_accept;
    logic               w_fmt_invalid;
    logic               w_misaligned;
    logic               w_last_beat;
    logic               w_wait_done;
    logic [31:0]        w_beat_addr;
    logic [2:0]         w_beat_fmt;
    logic [31:0]        w_beat_wdata;
    logic [31:0]        w_load_result;

    assign w_accept      = (r_state == c_st_idle) && req_valid && (read_enable || write_enable);
    assign w_fmt_invalid = (data_format[1:0] == 2'b11);
    assign w_misaligned  = ((data_format[1:0] == 2'b01) && address[0]) ||
                           ((data_format[1:0] == 2'b10) && (address[1:0] != 2'b00));
    assign w_last_beat   = (r_idx == r_last_idx);
    assign w_wait_done   = (r_wait_cnt == c_cnt_last);

    assign w_beat_addr   = r_addr + {30'd0, r_idx};
    assign w_beat_fmt    = r_split ? 3'b100 : r_fmt;
    assign w_beat_wdata  = r_split ? {24'd0, r_wdata[{r_idx, 3'b000} +: 8]} : r_wdata;

    // Split beats fill the accumulator from zero, so only half loads need extension.
    always_comb begin
        w_load_result = r_acc;
        if (r_split && !r_fmt[1] && !r_fmt[2]) begin
            w_load_result = {{16{r_acc[15]}}, r_acc[15:0]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        busy             = 1'b1;
        resp_valid       = 1'b0;
        resp_fault       = 1'b0;
        load_data        = 32'd0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = r_hold_addr;
        mem_data_format  = r_hold_fmt;
        mem_write_data   = r_hold_wdata;
        case (r_state)
            c_st_idle: begin
                busy = 1'b0;
                if (w_accept) begin
                    if (w_fmt_invalid || (w_misaligned && !c_split_en)) begin
                        w_state_next = c_st_done;
                    end else begin
                        w_state_next = c_st_issue;
                    end
                end
            end
            c_st_issue: begin
                mem_address     = w_beat_addr;
                mem_data_format = w_beat_fmt;
                mem_write_data  = w_beat_wdata;
                if (r_is_store) begin
                    mem_write_enable = 1'b1;
                    if (w_last_beat) begin
                        w_state_next = c_st_done;
                    end
                end else begin
                    mem_read_enable = 1'b1;
                    w_state_next    = c_st_wait;
                end
            end
            c_st_wait: begin
                mem_address     = w_beat_addr;
                mem_data_format = w_beat_fmt;
                mem_write_data  = w_beat_wdata;
                mem_read_enable = 1'b1;
                if (w_wait_done) begin
                    w_state_next = w_last_beat ? c_st_done : c_st_issue;
                end
            end
            default: begin
                resp_valid   = 1'b1;
                resp_fault   = r_fault;
                w_state_next = c_st_idle;
                if (!r_is_store && !r_fault) begin
                    load_data = w_load_result;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_is_store   <= 1'b0;
            r_split      <= 1'b0;
            r_fault      <= 1'b0;
            r_addr       <= 32'd0;
            r_fmt        <= 3'd0;
            r_wdata      <= 32'd0;
            r_idx        <= 2'd0;
            r_last_idx   <= 2'd0;
            r_acc        <= 32'd0;
            r_wait_cnt   <= '0;
            r_hold_addr  <= 32'd0;
            r_hold_fmt   <= 3'd0;
            r_hold_wdata <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_is_store <= write_enable;
                        r_addr     <= address;
                        r_fmt      <= data_format;
                        r_wdata    <= write_data;
                        r_split    <= w_misaligned && c_split_en;
                        r_fault    <= w_fmt_invalid || (w_misaligned && !c_split_en);
                        r_last_idx <= (w_misaligned && c_split_en) ?
                                      (data_format[1] ? 2'd3 : 2'd1) : 2'd0;
                        r_acc      <= 32'd0;
                        r_idx      <= 2'd0;
                        r_wait_cnt <= '0;
                    end
                end
                c_st_issue: begin
                    r_hold_addr  <= w_beat_addr;
                    r_hold_fmt   <= w_beat_fmt;
                    r_hold_wdata <= w_beat_wdata;
                    r_wait_cnt   <= '0;
                    if (r_is_store && !w_last_beat) begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                c_st_wait: begin
                    if (w_wait_done) begin
                        if (r_split) begin
                            r_acc[{r_idx, 3'b000} +: 8] <= mem_read_data[7:0];
                        end else begin
                            r_acc <= mem_read_data;
                        end
                        if (!w_last_beat) begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_load_store_sequencer
// Brief    : Scoreboard bench for load_store_sequencer with a byte-level
//            reference memory model and a behavioural data memory.
// Revision : 1.0 - initial release
//==============================================================================
module tb_load_store_sequencer;

    localparam int LAT = 2;
`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        read_enable;
    logic        write_enable;
    logic [2:0]  data_format;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        busy;
    logic        resp_valid;
    logic        resp_fault;
    logic [31:0] load_data;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [2:0]  mem_data_format;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    load_store_sequencer #(.READ_LATENCY(LAT)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .read_enable      (read_enable),
        .write_enable     (write_enable),
        .data_format      (data_format),
        .address          (address),
        .write_data       (write_data),
        .busy             (busy),
        .resp_valid       (resp_valid),
        .resp_fault       (resp_fault),
        .load_data        (load_data),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_data_format  (mem_data_format),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    typedef struct {
        logic        fault;
        logic [31:0] data;
        int          cyc;
        int          wr;
        int          rd;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [7:0]  dmem    [logic [31:0]];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] dmem_byte(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 8'h00;
    endfunction

    // Expected outcome of one accepted request, from byte-level semantics.
    function automatic exp_t model(input bit we, input logic [2:0] fmt,
                                   input logic [31:0] addr, input logic [31:0] wd, input int c);
        exp_t        e;
        int          size;
        int          n;
        bit          mis;
        logic [31:0] val;
        logic [31:0] a;
        e.fault = 1'b0; e.data = 32'd0; e.wr = 0; e.rd = 0; e.cyc = c + 1;
        if (fmt[1:0] == 2'b11) begin
            e.fault = 1'b1;
            return e;
        end
        size = 1 << fmt[1:0];
        mis  = (addr % size) != 0;
        if (mis && !SPLIT_EN) begin
            e.fault = 1'b1;
            return e;
        end
        n = mis ? size : 1;
        if (we) begin
            for (int i = 0; i < size; i++) begin
                a = addr + i;
                ref_mem[a] = wd[8*i +: 8];
            end
            e.cyc = c + 1 + n;
            e.wr  = n;
        end else begin
            val = 32'd0;
            for (int i = 0; i < size; i++) begin
                a = addr + i;
                val = val | (32'(ref_byte(a)) << (8*i));
            end
            if (!fmt[2] && size < 4 && val[8*size-1]) begin
                val = val | ~((32'd1 << (8*size)) - 32'd1);
            end
            e.data = val;
            e.cyc  = c + 1 + n * (1 + LAT);
            e.rd   = n * (1 + LAT);
        end
        return e;
    endfunction

    // Behavioural data memory: byte-addressed, returns extended read data.
    always @(negedge clock) begin
        logic [31:0] v;
        int          sz;
        logic [31:0] a;
        sz = 1 << mem_data_format[1:0];
        if (mem_write_enable) begin
            for (int i = 0; i < sz && i < 4; i++) begin
                a = mem_address + i;
                dmem[a] = mem_write_data[8*i +: 8];
            end
        end
        if (mem_read_enable) begin
            v = 32'd0;
            for (int i = 0; i < sz && i < 4; i++) begin
                a = mem_address + i;
                v = v | (32'(dmem_byte(a)) << (8*i));
            end
            if (!mem_data_format[2] && sz < 4 && v[8*sz-1]) begin
                v = v | ~((32'd1 << (8*sz)) - 32'd1);
            end
            mem_read_data = v;
        end
    end

    // Monitor: pops the scoreboard on every response.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            wr_cnt = 0;
            rd_cnt = 0;
        end else begin
            if (mem_write_enable) wr_cnt = wr_cnt + 1;
            if (mem_read_enable)  rd_cnt = rd_cnt + 1;
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_fault", 32'(resp_fault), 32'(e.fault));
                    chk("load_data", load_data, e.data);
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("write_beats", 32'(wr_cnt), 32'(e.wr));
                    chk("read_beats", 32'(rd_cnt), 32'(e.rd));
                end
                wr_cnt = 0;
                rd_cnt = 0;
            end
        end
    end

    // Called at a falling edge with busy low; returns at a falling edge with busy low.
    task automatic send(input bit we, input bit re, input logic [2:0] fmt,
                        input logic [31:0] addr, input logic [31:0] wd);
        int guard;
        req_valid    = 1'b1;
        write_enable = we;
        read_enable  = re;
        data_format  = fmt;
        address      = addr;
        write_data   = wd;
        if (we || re) sb.push_back(model(we, fmt, addr, wd, cyc));
        @(negedge clock);
        guard = 0;
        while (busy) begin
            req_valid    = ($urandom_range(0, 2) == 0);
            read_enable  = 1'($urandom_range(0, 1));
            write_enable = 1'($urandom_range(0, 1));
            data_format  = 3'($urandom);
            address      = $urandom;
            write_data   = $urandom;
            @(negedge clock);
            guard++;
            if (guard > 200) begin
                expire("busy_timeout");
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0000_1000;
            1:       base = 32'h0000_2000;
            default: base = 32'hFFFF_FFF8;
        endcase
        return base + 32'($urandom_range(0, 15));
    endfunction

    initial begin
        int          guard;
        bit          we;
        bit          re;
        logic [2:0]  fmt;
        mem_read_data = 32'd0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        data_format  = 3'd0;
        address      = 32'd0;
        write_data   = 32'd0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_rd_en", 32'(mem_read_enable), 32'd0);
        chk("rst_mem_wr_en", 32'(mem_write_enable), 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_mem_fmt", 32'(mem_data_format), 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        send(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF);
        send(1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'h0);
        send(1'b0, 1'b1, 3'b010, 32'h0000_1002, 32'h0);
        send(1'b0, 1'b1, 3'b011, 32'h0000_1000, 32'h0);
        send(1'b1, 1'b1, 3'b010, 32'h0000_1003, 32'h1122_3344);
        send(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0000_0080);
        send(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0000_00FF);
        send(1'b0, 1'b1, 3'b001, 32'h0000_2001, 32'h0);
        send(1'b0, 1'b1, 3'b101, 32'h0000_2001, 32'h0);
        send(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h0);
        send(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D);
        send(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'hA5A5_5A5A);
        send(1'b0, 1'b1, 3'b110, 32'hFFFF_FFFC, 32'h0);

        for (int k = 0; k < 250; k++) begin
            we  = 1'($urandom_range(0, 1));
            re  = ($urandom_range(0, 5) != 0);
            fmt = {1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2))};
            send(we, re, fmt, rand_addr(), $urandom);
        end

        // Reset during the wait phase of a load: enables drop at once, no response.
        req_valid    = 1'b1;
        read_enable  = 1'b1;
        write_enable = 1'b0;
        data_format  = 3'b010;
        address      = 32'h0000_1000;
        @(negedge clock);
        req_valid = 1'b0;
        chk("pre_rst_rd_en", 32'(mem_read_enable), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_rd_en", 32'(mem_read_enable), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_resp", 32'(resp_valid), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        send(1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'h0);

        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (sb.size() != 0) expire("drain_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_sequencer.md
# load_store_sequencer

Sequences core load/store requests into accesses on the data memory interface, which handles one in-word access per request and cannot cross a 32-bit word boundary. Aligned accesses are forwarded as a single memory access. Misaligned halfword and word accesses are split into unsigned byte accesses. Loaded bytes are reassembled and sign- or zero-extended. The block sits between the core's memory stage and the data memory interface, and stalls the core while a request is in flight.

## Interface
- `READ_LATENCY`, default 1: cycles from a read issue to valid `mem_read_data`; must be ≥1.
- `clock` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: one-cycle request strobe, sampled only in IDLE.
- `read_enable` in 1: request is a load.
- `write_enable` in 1: request is a store; wins if `read_enable` is also high.
- `data_format` in 3: [1:0] 00 byte, 01 half, 10 word, 11 invalid; [2]=1 unsigned load.
- `address` in 32: byte address.
- `write_data` in 32: store data, right-justified.
- `busy` out 1: high whenever state≠IDLE.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_fault` out 1: valid with `resp_valid`; misaligned (macro absent) or invalid format.
- `load_data` out 32: extended load result, valid with `resp_valid`; 0 for stores and faults.
- `mem_read_enable` out 1
- `mem_write_enable` out 1
- `mem_data_format` out 3
- `mem_address` out 32
- `mem_write_data` out 32: drives the data memory interface.
- `mem_read_data` in 32: extended data returned by the data memory interface.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE, accepting a request.** On `req_valid` with `read_enable`, `write_enable`, or both:
  - Latch op, address, format and write data.
  - Clear the byte accumulator and set idx=0.
- **Misaligned rule.** A half with `address[0]`=1 is misaligned. A word with `address[1:0]`≠0 is misaligned.
- **Beat count n.** n=1 if aligned. Otherwise n=2 for a half and n=4 for a word.
- **IDLE next state.**
  - Invalid format → DONE with fault.
  - Misaligned with the macro absent → DONE with fault.
  - Otherwise → ISSUE.
- **ISSUE** (one cycle): drive `mem_address` = latched address + idx, modulo 2^32.
  - Aligned beat:
    - `mem_data_format` = latched format.
    - `mem_write_data` = latched data.
  - Split beat:
    - `mem_data_format` = 3'b100.
    - `mem_write_data` = {24'b0, data[8·idx+7:8·idx]}.
  - Store:
    - Assert `mem_write_enable`.
    - If idx=n−1 → DONE; else idx+1 and stay in ISSUE.
  - Load:
    - Assert `mem_read_enable`.
    - → WAIT.
- **WAIT** (`READ_LATENCY` cycles):
  - Hold the ISSUE address, format and `mem_read_enable`.
  - On the last cycle, capture `mem_read_data`: the whole word if aligned, else bits [7:0] into accumulator byte idx.
  - If idx=n−1 → DONE; else idx+1 → ISSUE.
- **DONE** (one cycle):
  - Assert `resp_valid`; → IDLE.
  - Split loads: `load_data` is the accumulator, sign-extended from bit 15 or 31 per format unless format[2]=1.
  - Aligned loads: `load_data` is passed through unchanged.
- **Mem outputs outside ISSUE/WAIT.** Enables are 0. `mem_address`, `mem_data_format` and `mem_write_data` hold their last value.
- **`req_valid` while busy** is ignored; no queueing.

## Timing
- **Reset values.**
  - State IDLE; `busy`, `resp_valid`, `resp_fault` 0.
  - `load_data` 0.
  - All mem enables 0; `mem_address` 0; `mem_data_format` 0; `mem_write_data` 0.
- **Reset mid-operation.**
  - Immediate return to IDLE and enables drop asynchronously.
  - Bytes already written stay written; no response is produced.
- **Latency.** Let L=`READ_LATENCY`; T is the edge that accepts the request. `resp_valid` is high in cycle:
  - aligned store: T+2
  - aligned load: T+2+L
  - split store: T+1+n
  - split load: T+1+n·(1+L)
  - fault: T+1
- **`busy`** rises in the cycle after acceptance and falls in the cycle after DONE.
- **Back-to-back requests.** The next request can be accepted in the cycle after DONE (on the edge ending the first IDLE cycle).

## Configuration
- `MISALIGNED_SPLIT_EN`:
  - Defined: misaligned halfword and word accesses are split as above, and `resp_fault` fires only on invalid format.
  - Undefined: misaligned accesses issue no memory access and complete in DONE with `resp_fault`=1 and `load_data`=0. WAIT and ISSUE only ever run single beats.

## Test plan
- **Aligned word store/load.** Store 0xDEADBEEF at 0x1000, then load a word from 0x1000 → `load_data` 0xDEADBEEF. `resp_valid` at T+2 for the store and T+3 for the load (L=1).
- **Misaligned word store (macro on).** Store 0x11223344 at 0x1003 → four byte writes to 0x1003..0x1006 with data 0x44, 0x33, 0x22, 0x11; response at T+5.
- **Misaligned signed half load (macro on).** Bytes 0x80 at 0x2001 and 0xFF at 0x2002, load half from 0x2001 → 0xFFFFFF80. Same load with format 3'b101 → 0x0000FF80.
- **Macro off.** Word load at 0x1002 → no mem enable pulses; `resp_fault`=1 and `load_data`=0 at T+1.
- **Invalid format and busy handling.** `data_format`=3'b011 → fault at T+1. `req_valid` pulsed during a busy split load is ignored, with no extra beats.
- **Wrap and reset.** Word store at 0xFFFFFFFE addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Asserting `reset` at beat 2 → enables low the same cycle, state IDLE, no `resp_valid`.
